// File: rtl/ram_sync_master_if.sv
// Bus bundle between ram_sync_master, its command/data agents and the synchronous RAM.
// The master modport is the controller's view; slave is the view of everything around it.
interface ram_sync_master_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] cmd_len;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              done;
    logic              err;
    logic              mem_writeOn;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  wr_valid, wr_data, rd_ready, mem_data_out,
        output cmd_ready, wr_ready, rd_valid, rd_data,
        output busy, done, err, mem_writeOn, mem_address, mem_data_in
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output wr_valid, wr_data, rd_ready, mem_data_out,
        input  cmd_ready, wr_ready, rd_valid, rd_data,
        input  busy, done, err, mem_writeOn, mem_address, mem_data_in
    );
endinterface

// File: rtl/ram_sync_master.sv
// Burst controller that owns every port of the synchronous single-port RAM.
// Define RAM_READ_PIPE_EN for the streaming read path (2-entry FIFO, 1 beat/clk).
module ram_sync_master #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    ram_sync_master_if.master bus
);
    typedef enum logic [2:0] {IDLE, WR, RD_ADDR, RD_WAIT, RD_OUT, FIN} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic [ADDR_W-1:0] remaining, remaining_n;
    logic              err_q, err_n;

`ifdef RAM_READ_PIPE_EN
    logic [DATA_W-1:0] fifo [2];
    logic [1:0]        occ, occ_n;
    logic              wptr, rptr;
    logic              inflight;
    logic              push, pop, issue;
    logic [2:0]        load;
    logic [ADDR_W:0]   issue_left, issue_left_n;
`else
    logic [DATA_W-1:0] rd_data_q, rd_data_n;
`endif

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            err_q     <= 1'b0;
`ifdef RAM_READ_PIPE_EN
            fifo[0]    <= '0;
            fifo[1]    <= '0;
            occ        <= 2'd0;
            wptr       <= 1'b0;
            rptr       <= 1'b0;
            inflight   <= 1'b0;
            issue_left <= '0;
`else
            rd_data_q <= '0;
`endif
        end else begin
            state     <= state_n;
            addr      <= addr_n;
            remaining <= remaining_n;
            err_q     <= err_n;
`ifdef RAM_READ_PIPE_EN
            occ        <= occ_n;
            inflight   <= issue;
            issue_left <= issue_left_n;
            if (push) begin
                fifo[wptr] <= bus.mem_data_out;
                wptr       <= ~wptr;
            end
            if (pop) begin
                rptr <= ~rptr;
            end
`else
            rd_data_q <= rd_data_n;
`endif
        end
    end

    // RAM strobes are gated by state so a reset or a stray beat can never write.
    always_comb begin
        state_n         = state;
        addr_n          = addr;
        remaining_n     = remaining;
        err_n           = err_q;
        bus.cmd_ready   = (state == IDLE);
        bus.busy        = (state != IDLE);
        bus.done        = (state == FIN);
        bus.err         = (state == FIN) && err_q;
        bus.wr_ready    = (state == WR);
        bus.mem_writeOn = (state == WR) && bus.wr_valid;
        bus.mem_address = addr;
        bus.mem_data_in = (state == WR) ? bus.wr_data : '0;
`ifdef RAM_READ_PIPE_EN
        // An address may issue whenever the FIFO still has room after this cycle's pop.
        push         = inflight;
        pop          = (state == RD_OUT) && (occ != 2'd0) && bus.rd_ready;
        load         = {1'b0, occ} + {2'b00, inflight};
        issue        = (state == RD_OUT) && (issue_left != '0) && (load < (3'd2 + {2'b00, pop}));
        occ_n        = occ + {1'b0, push} - {1'b0, pop};
        issue_left_n = issue_left;
        bus.rd_valid = (state == RD_OUT) && (occ != 2'd0);
        bus.rd_data  = fifo[rptr];
`else
        rd_data_n    = rd_data_q;
        bus.rd_valid = (state == RD_OUT);
        bus.rd_data  = rd_data_q;
`endif
        case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    addr_n      = bus.cmd_addr;
                    remaining_n = bus.cmd_len;
                    err_n       = ({1'b0, bus.cmd_addr} >= DEPTH_EXT);
                    if (err_n) begin
                        state_n = FIN;
                    end else if (bus.cmd_write) begin
                        state_n = WR;
                    end else begin
`ifdef RAM_READ_PIPE_EN
                        issue_left_n = {1'b0, bus.cmd_len} + 1'b1;
                        state_n      = RD_OUT;
`else
                        state_n = RD_ADDR;
`endif
                    end
                end
            end
            WR: begin
                if (bus.wr_valid) begin
                    addr_n = next_addr(addr);
                    if (remaining == '0) begin
                        state_n = FIN;
                    end else begin
                        remaining_n = remaining - 1'b1;
                    end
                end
            end
            RD_ADDR: begin
                state_n = RD_WAIT;
            end
            RD_WAIT: begin
`ifndef RAM_READ_PIPE_EN
                rd_data_n = bus.mem_data_out;
`endif
                state_n = RD_OUT;
            end
            RD_OUT: begin
`ifdef RAM_READ_PIPE_EN
                if (issue) begin
                    addr_n       = next_addr(addr);
                    issue_left_n = issue_left - 1'b1;
                end
                if ((issue_left == '0) && !inflight && (occ_n == 2'd0)) begin
                    state_n = FIN;
                end
`else
                if (bus.rd_ready) begin
                    if (remaining == '0) begin
                        state_n = FIN;
                    end else begin
                        addr_n      = next_addr(addr);
                        remaining_n = remaining - 1'b1;
                        state_n     = RD_ADDR;
                    end
                end
`endif
            end
            FIN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_ram_sync_master.sv
// Directed bench for ram_sync_master with a write-first 1-latency RAM model and scoreboard queues.
// Build with RAM_READ_PIPE_EN to check the streaming read timing as well.
module tb_ram_sync_master;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;
    localparam int RAM_AW = $clog2(DEPTH);

`ifdef RAM_READ_PIPE_EN
    localparam int RD4_DONE = 7;
    localparam int RD8_DONE = 11;
`else
    localparam int RD4_DONE = 13;
    localparam int RD8_DONE = 25;
`endif

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    wr_exp_t           wrQ [$];
    logic [DATA_W-1:0] rdQ [$];

    logic [DATA_W-1:0] ram [DEPTH];
    logic [DATA_W-1:0] ram_dout;

    always #5 clk = ~clk;

    ram_sync_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ram_sync_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Synchronous single-port RAM: one clock read latency, write-first.
    always @(posedge clk) begin
        if (bus.mem_writeOn) begin
            ram[bus.mem_address[RAM_AW-1:0]] <= bus.mem_data_in;
            ram_dout                         <= bus.mem_data_in;
        end else begin
            ram_dout <= ram[bus.mem_address[RAM_AW-1:0]];
        end
    end
    assign bus.mem_data_out = ram_dout;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic write,
                                 input logic [ADDR_W-1:0] addr, input logic [ADDR_W-1:0] len);
        bus.cmd_valid = valid;
        bus.cmd_write = write;
        bus.cmd_addr  = addr;
        bus.cmd_len   = len;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic runWrite(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] l,
                            input logic [DATA_W-1:0] base);
        wr_exp_t           e;
        logic [ADDR_W-1:0] ea;
        applyStimulus(1'b1, 1'b1, a, l);
        #1;
        checkOutput("wr_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0);
        ea = a;
        for (int i = 0; i <= int'(l); i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = base + 32'(i);
            e.a = ea;
            e.d = base + 32'(i);
            wrQ.push_back(e);
            ea = (ea == ADDR_W'(DEPTH - 1)) ? '0 : ea + 1'b1;
            #1;
            checkOutput("wr_on", 64'(bus.mem_writeOn), 64'd1);
            if (bus.mem_writeOn && (wrQ.size() > 0)) begin
                e = wrQ.pop_front();
                checkOutput("wr_addr", 64'(bus.mem_address), 64'(e.a));
                checkOutput("wr_data", 64'(bus.mem_data_in), 64'(e.d));
            end
            tick();
        end
        bus.wr_data = 32'hDEAD_BEEF;
        #1;
        checkOutput("wr_done", 64'(bus.done), 64'd1);
        checkOutput("wr_err", 64'(bus.err), 64'd0);
        checkOutput("wr_extra_beat_ignored", 64'(bus.mem_writeOn), 64'd0);
        checkOutput("wr_ready_fin", 64'(bus.wr_ready), 64'd0);
        tick();
        bus.wr_valid = 1'b0;
        #1;
        checkOutput("wr_done_pulse", 64'(bus.done), 64'd0);
        checkOutput("wr_back_idle", 64'(bus.cmd_ready), 64'd1);
    endtask

    // Expected read data must already sit in rdQ; the rd_ready pattern 1,0,0,1 repeats per cycle.
    task automatic runRead(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] l, input bit backpressure,
                           output int nDone, output int nXfer, output int firstValid);
        int                cyc;
        int                wrSeen;
        bit                holding;
        bit                gotDone;
        logic [DATA_W-1:0] held;
        logic [DATA_W-1:0] exp;
        applyStimulus(1'b1, 1'b0, a, l);
        bus.rd_ready = 1'b0;
        #1;
        checkOutput("rd_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0);
        cyc = 1; nXfer = 0; firstValid = 0; nDone = 0;
        wrSeen = 0; holding = 1'b0; gotDone = 1'b0; held = '0;
        while (!gotDone && (cyc < 300)) begin
            bus.rd_ready = backpressure ? (((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3)) : 1'b1;
            #1;
            if (bus.mem_writeOn) wrSeen++;
            if (bus.done) begin
                gotDone = 1'b1;
                nDone   = cyc;
            end else begin
                if (bus.rd_valid) begin
                    if (firstValid == 0) firstValid = cyc;
                    if (holding) checkOutput("rd_hold_stable", 64'(bus.rd_data), 64'(held));
                    if (bus.rd_ready) begin
                        checkOutput("rd_beat_expected", 64'(rdQ.size() > 0), 64'd1);
                        if (rdQ.size() > 0) begin
                            exp = rdQ.pop_front();
                            checkOutput("rd_data", 64'(bus.rd_data), 64'(exp));
                        end
                        nXfer++;
                        holding = 1'b0;
                    end else begin
                        held    = bus.rd_data;
                        holding = 1'b1;
                    end
                end
                tick();
                cyc++;
            end
        end
        checkOutput("rd_done_seen", 64'(gotDone), 64'd1);
        checkOutput("rd_err", 64'(bus.err), 64'd0);
        checkOutput("rd_no_ram_write", 64'(wrSeen), 64'd0);
        checkOutput("rd_all_consumed", 64'(rdQ.size()), 64'd0);
        bus.rd_ready = 1'b0;
        tick();
    endtask

    initial begin
        int                nDone, nXfer, firstValid;
        logic [DATA_W-1:0] prev12, prev13;

        applyStimulus(1'b0, 1'b0, '0, '0);
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.rd_ready = 1'b0;
        rst_n        = 1'b0;
        tick();
        tick();
        checkOutput("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        checkOutput("rst_wr_ready", 64'(bus.wr_ready), 64'd0);
        checkOutput("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
        checkOutput("rst_rd_data", 64'(bus.rd_data), 64'd0);
        checkOutput("rst_busy", 64'(bus.busy), 64'd0);
        checkOutput("rst_done", 64'(bus.done), 64'd0);
        checkOutput("rst_err", 64'(bus.err), 64'd0);
        checkOutput("rst_mem_writeOn", 64'(bus.mem_writeOn), 64'd0);
        checkOutput("rst_mem_address", 64'(bus.mem_address), 64'd0);
        checkOutput("rst_mem_data_in", 64'(bus.mem_data_in), 64'd0);
        rst_n = 1'b1;
        tick();

        $display("[TB] write burst addr=4 len=3");
        runWrite(6'd4, 6'd3, 32'hA0);
        for (int i = 0; i < 4; i++) checkOutput("ram_4_7", 64'(ram[4 + i]), 64'(32'hA0 + i));

        $display("[TB] read burst addr=4 len=3 with backpressure");
        for (int i = 0; i < 4; i++) rdQ.push_back(32'hA0 + 32'(i));
        runRead(6'd4, 6'd3, 1'b1, nDone, nXfer, firstValid);
        checkOutput("rd_bp_transfers", 64'(nXfer), 64'd4);

        $display("[TB] wrapping write addr=30 len=3 and read-back");
        runWrite(6'd30, 6'd3, 32'hB0);
        checkOutput("wrap_ram30", 64'(ram[30]), 64'hB0);
        checkOutput("wrap_ram31", 64'(ram[31]), 64'hB1);
        checkOutput("wrap_ram0", 64'(ram[0]), 64'hB2);
        checkOutput("wrap_ram1", 64'(ram[1]), 64'hB3);
        for (int i = 0; i < 4; i++) rdQ.push_back(32'hB0 + 32'(i));
        runRead(6'd30, 6'd3, 1'b0, nDone, nXfer, firstValid);
        checkOutput("wrap_rd_transfers", 64'(nXfer), 64'd4);
        checkOutput("wrap_rd_first_valid", 64'(firstValid), 64'd3);
        checkOutput("wrap_rd_done_cycle", 64'(nDone), 64'(RD4_DONE));

        $display("[TB] eight-beat write and streaming read at addr=16");
        runWrite(6'd16, 6'd7, 32'hD0);
        for (int i = 0; i < 8; i++) rdQ.push_back(32'hD0 + 32'(i));
        runRead(6'd16, 6'd7, 1'b0, nDone, nXfer, firstValid);
        checkOutput("rd8_transfers", 64'(nXfer), 64'd8);
        checkOutput("rd8_first_valid", 64'(firstValid), 64'd3);
        checkOutput("rd8_done_cycle", 64'(nDone), 64'(RD8_DONE));
`ifdef RAM_READ_PIPE_EN
        checkOutput("rd8_back_to_back", 64'(nDone - firstValid), 64'd8);
`endif

        $display("[TB] out-of-range command addr=40");
        bus.wr_valid = 1'b1;
        bus.wr_data  = 32'h5555_5555;
        applyStimulus(1'b1, 1'b1, 6'd40, 6'd3);
        #1;
        checkOutput("err_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0);
        #1;
        checkOutput("err_done", 64'(bus.done), 64'd1);
        checkOutput("err_flag", 64'(bus.err), 64'd1);
        checkOutput("err_no_write", 64'(bus.mem_writeOn), 64'd0);
        checkOutput("err_wr_ready", 64'(bus.wr_ready), 64'd0);
        tick();
        checkOutput("err_done_pulse", 64'(bus.done), 64'd0);
        checkOutput("err_flag_clear", 64'(bus.err), 64'd0);
        checkOutput("err_back_idle", 64'(bus.cmd_ready), 64'd1);
        bus.wr_valid = 1'b0;

        $display("[TB] reset in the middle of a write burst");
        prev12 = ram[12];
        prev13 = ram[13];
        applyStimulus(1'b1, 1'b1, 6'd10, 6'd5);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0);
        bus.wr_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.wr_data = 32'hC0 + 32'(i);
            tick();
        end
        bus.wr_data = 32'hC2;
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_writeOn", 64'(bus.mem_writeOn), 64'd0);
        checkOutput("midrst_busy", 64'(bus.busy), 64'd0);
        checkOutput("midrst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        checkOutput("midrst_wr_ready", 64'(bus.wr_ready), 64'd0);
        tick();
        tick();
        checkOutput("midrst_ram10", 64'(ram[10]), 64'hC0);
        checkOutput("midrst_ram11", 64'(ram[11]), 64'hC1);
        checkOutput("midrst_ram12_kept", 64'(ram[12]), 64'(prev12));
        checkOutput("midrst_ram13_kept", 64'(ram[13]), 64'(prev13));
        bus.wr_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        checkOutput("after_rst_idle", 64'(bus.cmd_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
